sha256d_nonce_sequencer: RTL and testbench

- Drives one `sha256_unrolled`-style compression core to perform Bitcoin double-SHA-256 over a range of nonces.
- Per nonce: hash 1 compresses the header's second chunk from a host-supplied midstate; hash 2 compresses the padded 256-bit digest from the SHA-256 IV.
- Serves the core's word-request bus, checks each result against a leading-zero difficulty, and reports the hit, exhaustion or abort to the host.

---
 rtl/sha256d_nonce_sequencer.sv | 141 ++++++++++++++
 tb/tb_sha256d_nonce_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256d_nonce_sequencer.sv
// sha256d_nonce_sequencer: drives one SHA-256 compression core through the double hash
// of every nonce in an inclusive, possibly wrapping, range and reports leading-zero hits.
module sha256d_nonce_sequencer #(
   parameter logic STOP_ON_HIT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [255:0] midstate,
   input  logic [95:0]  tail,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [5:0]   zero_bits,
   output logic         busy,
   output logic         found,
   output logic [31:0]  found_nonce,
   output logic [255:0] digest,
   output logic         exhausted,
   output logic         aborted,
   output logic [31:0]  hash_count,
   output logic         core_start,
   output logic [255:0] core_state_in,
   input  logic         core_rq,
   input  logic [3:0]   core_addr,
   output logic [31:0]  core_data,
   output logic         core_rdy,
   input  logic [255:0] core_state_out,
   input  logic         core_done
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_H1_GO  = 3'd1;
   localparam logic [2:0] S_H1_RUN = 3'd2;
   localparam logic [2:0] S_H2_GO  = 3'd3;
   localparam logic [2:0] S_H2_RUN = 3'd4;
   localparam logic [2:0] S_CHECK  = 3'd5;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   logic [2:0]   state;
   logic [255:0] mid_r, d1, d2, d1_sh;
   logic [95:0]  tail_r;
   logic [31:0]  nonce, nonce_end_r, w1, w2, word, v;
   logic [5:0]   zb_r;
   logic         stop_pending, iv_sel, run, serve, hit;
   assign busy = state != S_IDLE;
   assign core_start = state == S_H1_GO || state == S_H2_GO;
   // the selected initial state stays put from one GO state until the next
   assign core_state_in = iv_sel ? IV : mid_r;
   assign run = state == S_H1_RUN || state == S_H2_RUN;
   assign serve = run && core_rq && !core_rdy;
   assign d1_sh = d1 >> {~core_addr[2:0], 5'd0};
   always_comb begin
      w1 = core_addr == 4'd0  ? tail_r[95:64] :
           core_addr == 4'd1  ? tail_r[63:32] :
           core_addr == 4'd2  ? tail_r[31:0]  :
           core_addr == 4'd3  ? nonce         :
           core_addr == 4'd4  ? 32'h80000000  :
           core_addr == 4'd15 ? 32'h00000280  : 32'd0;
      w2 = !core_addr[3]      ? d1_sh[31:0]   :
           core_addr == 4'd8  ? 32'h80000000  :
           core_addr == 4'd15 ? 32'h00000100  : 32'd0;
      word = state == S_H1_RUN ? w1 : w2;
   end
   // difficulty is judged on the last digest word read as little-endian
   assign v = {d2[7:0], d2[15:8], d2[23:16], d2[31:24]};
   assign hit = zb_r == 6'd0 || (v >> (6'd32 - zb_r)) == 32'd0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         mid_r        <= '0;
         tail_r       <= '0;
         d1           <= '0;
         d2           <= '0;
         nonce        <= '0;
         nonce_end_r  <= '0;
         zb_r         <= '0;
         stop_pending <= 1'b0;
         iv_sel       <= 1'b0;
         found        <= 1'b0;
         found_nonce  <= '0;
         digest       <= '0;
         exhausted    <= 1'b0;
         aborted      <= 1'b0;
         hash_count   <= '0;
         core_rdy     <= 1'b0;
         core_data    <= '0;
      end else begin
         found     <= 1'b0;
         exhausted <= 1'b0;
         aborted   <= 1'b0;
         core_rdy  <= serve;
         if (serve) core_data <= word;
         if (busy && stop) stop_pending <= 1'b1;
         case (state)
            S_IDLE: if (start) begin
               mid_r        <= midstate;
               tail_r       <= tail;
               nonce        <= nonce_start;
               nonce_end_r  <= nonce_end;
               zb_r         <= zero_bits > 6'd32 ? 6'd32 : zero_bits;
               hash_count   <= '0;
               stop_pending <= 1'b0;
               iv_sel       <= 1'b0;
               state        <= S_H1_GO;
            end
            S_H1_GO: state <= S_H1_RUN;
            S_H1_RUN: if (core_done) begin
               d1     <= core_state_out;
               iv_sel <= 1'b1;
               state  <= S_H2_GO;
            end
            S_H2_GO: state <= S_H2_RUN;
            S_H2_RUN: if (core_done) begin
               d2    <= core_state_out;
               state <= S_CHECK;
            end
            S_CHECK: begin
               hash_count <= hash_count + 32'd1;
               if (hit) begin
                  found       <= 1'b1;
                  found_nonce <= nonce;
                  digest      <= d2;
               end
               if (hit && STOP_ON_HIT) state <= S_IDLE;
               else if (stop_pending) begin
                  aborted <= 1'b1;
                  state   <= S_IDLE;
               end else if (nonce == nonce_end_r) begin
                  exhausted <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  nonce  <= nonce + 32'd1;
                  iv_sel <= 1'b0;
                  state  <= S_H1_GO;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256d_nonce_sequencer.sv
// tb_sha256d_nonce_sequencer: two sequencers (stop-on-hit and continuous) each driving a
// behavioural compression core, scored against a software double-SHA-256 range scan.
module tb_sha256d_nonce_sequencer;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   typedef struct {
      int           kind;
      logic [31:0]  nonce;
      logic [255:0] dig;
      logic [31:0]  hc;
   } ev_t;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   start = '0;
   logic [1:0]   stop = '0;
   logic [255:0] midstate = '0;
   logic [95:0]  tail = '0;
   logic [31:0]  nonce_start = '0;
   logic [31:0]  nonce_end = '0;
   logic [5:0]   zero_bits = '0;
   logic [1:0]   busy_v;
   logic [1:0][15:0] nstart_v, nrdy_v;
   logic [255:0] exp_mid [2];
   ev_t          evq [2][$];
   logic [31:0]  w3q [2][$];
   int           checks = 0;
   int           errors = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] s [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
                (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25)) +
              ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[i] + w[i];
         t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22)) +
              ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
         s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
         s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = s[i] + hin[255-32*i -: 32];
      return r;
   endfunction
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask
   task automatic pop_check(input int gi, input int kind, input logic [31:0] fn,
                            input logic [255:0] dg, input logic [31:0] hc);
      ev_t e;
      if (evq[gi].size() == 0) begin
         flag($sformatf("unexpected_event inst%0d kind%0d", gi, kind));
         return;
      end
      e = evq[gi].pop_front();
      check("event_kind", 256'(kind), 256'(e.kind));
      check("hash_count", hc, e.hc);
      if (kind == 1) begin
         check("found_nonce", fn, e.nonce);
         check("digest", dg, e.dig);
      end
   endtask
   // software scan: every nonce double-hashed, hit = enough leading zeros in the
   // byte-reversed last digest word
   task automatic model_scan(input int gi, input logic [31:0] ns, input logic [31:0] ne,
                             input logic [5:0] zb, input logic soh, input int abort_after,
                             output int n);
      logic [31:0] nc = ns;
      logic [255:0] d1, d2;
      logic [31:0] v;
      int zbe = zb > 32 ? 32 : int'(zb);
      int lz;
      n = 0;
      while (1) begin
         d1 = sha_compress(midstate, {tail, nc, 32'h80000000, 320'd0, 32'h00000280});
         d2 = sha_compress(IV, {d1, 32'h80000000, 192'd0, 32'h00000100});
         v = {d2[7:0], d2[15:8], d2[23:16], d2[31:24]};
         lz = 0;
         while (lz < 32 && !v[31-lz]) lz++;
         n++;
         w3q[gi].push_back(nc);
         if (lz >= zbe) evq[gi].push_back('{1, nc, d2, 32'(n)});
         if (lz >= zbe && soh) break;
         if (abort_after != 0 && n >= abort_after) begin
            evq[gi].push_back('{3, 32'd0, 256'd0, 32'(n)});
            break;
         end
         if (nc == ne) begin
            evq[gi].push_back('{2, 32'd0, 256'd0, 32'(n)});
            break;
         end
         nc = nc + 32'd1;
      end
   endtask
   for (genvar g = 0; g < 2; g++) begin : u
      logic         busy, found, exhausted, aborted, cstart, crq, crdy, cdone;
      logic [31:0]  found_nonce, hash_count, cdata;
      logic [255:0] digest, cst_in, cout;
      logic [3:0]   caddr;
      int           cs, k, lat;
      logic         phase, w3_seen, st_seen, st_phase, pend_b;
      logic [511:0] blk;
      logic [255:0] cst, st_val;
      logic [31:0]  w3_val;
      logic [15:0]  nstart, nrdy;
      sha256d_nonce_sequencer #(.STOP_ON_HIT(g == 0)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .stop(stop[g]),
         .midstate(midstate), .tail(tail), .nonce_start(nonce_start), .nonce_end(nonce_end),
         .zero_bits(zero_bits), .busy(busy), .found(found), .found_nonce(found_nonce),
         .digest(digest), .exhausted(exhausted), .aborted(aborted), .hash_count(hash_count),
         .core_start(cstart), .core_state_in(cst_in), .core_rq(crq), .core_addr(caddr),
         .core_data(cdata), .core_rdy(crdy), .core_state_out(cout), .core_done(cdone));
      assign busy_v[g] = busy;
      assign nstart_v[g] = nstart;
      assign nrdy_v[g] = nrdy;
      // compression core: fetch 16 words one request at a time, then a random latency
      always @(posedge clk) begin
         st_seen <= 1'b0;
         w3_seen <= 1'b0;
         if (rst) begin
            cs <= 0; crq <= 1'b0; cdone <= 1'b0; phase <= 1'b0;
            caddr <= '0; cout <= '0; nstart <= '0; nrdy <= '0;
         end else begin
            cdone <= 1'b0;
            if (cstart) nstart <= nstart + 16'd1;
            if (crdy) nrdy <= nrdy + 16'd1;
            if (cs == 0 && cstart) begin
               cst <= cst_in; st_val <= cst_in; st_seen <= 1'b1; st_phase <= phase;
               phase <= ~phase; k <= 0; crq <= 1'b1; caddr <= 4'd0; cs <= 1;
            end else if (cs == 1 && crdy) begin
               blk[511-32*k -: 32] <= cdata;
               if (k == 3 && phase) begin
                  w3_seen <= 1'b1;
                  w3_val <= cdata;
               end
               if (k == 15) begin
                  crq <= 1'b0; cs <= 2; lat <= int'($urandom_range(0, 6));
               end else begin
                  k <= k + 1; caddr <= 4'(k + 1);
               end
            end else if (cs == 2) begin
               if (lat == 0) begin
                  cout <= sha_compress(cst, blk); cdone <= 1'b1; cs <= 0;
               end else lat <= lat - 1;
            end
         end
      end
      always @(negedge clk) begin
         if (!rst) begin
            if (found) pop_check(g, 1, found_nonce, digest, hash_count);
            if (exhausted) pop_check(g, 2, found_nonce, digest, hash_count);
            if (aborted) pop_check(g, 3, found_nonce, digest, hash_count);
            if (pend_b) check("busy_after_end", 256'(busy), 256'd0);
            if (w3_seen) begin
               if (w3q[g].size() == 0) flag("unexpected_block1_nonce");
               else check("block1_w3", w3_val, w3q[g].pop_front());
            end
            if (st_seen) check("core_state_in", st_val, st_phase ? IV : exp_mid[g]);
         end
         pend_b <= !rst && (exhausted || aborted);
      end
   end
   task automatic rst_chk();
      check("rst_flags", {u[0].busy, u[0].found, u[0].exhausted, u[0].aborted, u[0].cstart, u[0].crdy}, 0);
      check("rst_found_nonce", u[0].found_nonce, 0);
      check("rst_hash_count", u[0].hash_count, 0);
      check("rst_digest", u[0].digest, 0);
      check("rst_core_state_in", u[0].cst_in, 0);
      check("rst_core_data", u[0].cdata, 0);
   endtask
   task automatic load(input logic [31:0] ns, input logic [31:0] ne, input logic [5:0] zb);
      midstate = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tail = {$urandom, $urandom, $urandom};
      nonce_start = ns;
      nonce_end = ne;
      zero_bits = zb;
   endtask
   task automatic run_scan(input int gi, input logic [31:0] ns, input logic [31:0] ne,
                           input logic [5:0] zb, input int abort_after);
      int n, t;
      logic [15:0] s0, r0;
      load(ns, ne, zb);
      exp_mid[gi] = midstate;
      model_scan(gi, ns, ne, zb, gi == 0, abort_after, n);
      s0 = nstart_v[gi];
      r0 = nrdy_v[gi];
      @(negedge clk) start[gi] = 1'b1;
      @(negedge clk) start[gi] = 1'b0;
      repeat (6) @(negedge clk);
      load($urandom, $urandom, 6'($urandom_range(0, 40)));
      start[gi] = 1'b1;
      @(negedge clk) start[gi] = 1'b0;
      if (abort_after != 0) begin
         t = 0;
         while (nstart_v[gi] != s0 + 16'(2 * abort_after - 1) && t < 5000) begin
            @(negedge clk); t++;
         end
         if (t >= 5000) flag("timeout_waiting_for_last_nonce");
         repeat (5) @(negedge clk);
         stop[gi] = 1'b1;
         @(negedge clk) stop[gi] = 1'b0;
      end
      t = 0;
      while (busy_v[gi] && t < 5000) begin
         @(negedge clk); t++;
      end
      if (busy_v[gi]) flag("timeout_waiting_for_idle");
      repeat (4) @(negedge clk);
      check("core_start_count", 256'(16'(nstart_v[gi] - s0)), 256'(16'(2 * n)));
      check("core_rdy_count", 256'(16'(nrdy_v[gi] - r0)), 256'(16'(32 * n)));
      check("events_left", 256'(evq[gi].size()), 256'd0);
      check("nonces_left", 256'(w3q[gi].size()), 256'd0);
      evq[gi].delete();
      w3q[gi].delete();
   endtask
   initial begin
      int t;
      logic [31:0] r;
      exp_mid[0] = '0;
      exp_mid[1] = '0;
      repeat (3) @(negedge clk);
      rst_chk();
      rst = 1'b0;
      @(negedge clk);
      run_scan(0, 32'd5, 32'd5, 6'd0, 0);
      run_scan(0, 32'd0, 32'd3, 6'd32, 0);
      run_scan(0, 32'hFFFFFFFE, 32'd1, 6'd32, 0);
      run_scan(1, 32'd10, 32'd12, 6'd0, 0);
      run_scan(0, 32'd10, 32'd12, 6'd0, 0);
      run_scan(0, 32'd0, 32'd100, 6'd32, 2);
      r = $urandom;
      run_scan(1, r, r + 32'd2, 6'd40, 0);
      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         run_scan(int'($urandom_range(0, 1)), r, r + 32'($urandom_range(0, 3)),
                  6'($urandom_range(0, 10)), 0);
      end
      @(negedge clk) stop[0] = 1'b1;
      @(negedge clk) stop[0] = 1'b0;
      run_scan(0, 32'd20, 32'd21, 6'd32, 0);
      load(32'd0, 32'd100, 6'd32);
      exp_mid[0] = midstate;
      w3q[0].push_back(32'd0);
      r = 32'(nstart_v[0]);
      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      t = 0;
      while (32'(nstart_v[0]) != r + 32'd2 && t < 5000) begin
         @(negedge clk); t++;
      end
      if (t >= 5000) flag("timeout_waiting_for_hash2");
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst_chk();
      check("rst_nonces_left", 256'(w3q[0].size()), 256'd0);
      rst = 1'b0;
      w3q[0].delete();
      @(negedge clk);
      run_scan(0, 32'd7, 32'd7, 6'd0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
